ddr_test_seq_ctrl: RTL and testbench
====================================

// Module: ddr_test_seq_ctrl
// PURPOSE
//  Top-level sequencer for the DDR traffic test. Runs the init-fill phase, then
//  schedules write and read bursts into the write and read test controllers.
//  Generates the per-burst address/len/id/ap fields, counts bursts and read errors,
//  and reports pass/fail. It sits between the board-level start/status logic and
//  the write/read controllers.
// PARAMETERS
//  CTRL_ADDR_WIDTH  28     AXI address width
//  MEM_SPACE_AW     18     tested address space = 2**MEM_SPACE_AW; must be >= 8
//  BURST_NUM        256    bursts per pass (1..65535)
//  LFSR_SEED        16'hACE1  address/len LFSR seed; must be non-zero
//  TIMEOUT_CYC      4096   watchdog limit in clk cycles (SEQ_TIMEOUT_EN only)
// PORTS
//  clk             in   1   system clock
//  rst             in   1   asynchronous reset, active-high
//  test_start      in   1   level; rising edge starts a test, low aborts to S_IDLE
//  write_to_read   in   1   1: read back each write immediately; 0: all writes, then all reads
//  rand_len_en     in   1   1: len = LFSR[3:0]; 0: len = 4'd15
//  rand_ap_en      in   1   1: ap = LFSR[4]; 0: ap = 0
//  init_done       in   1   write controller finished the init fill
//  wr_done_p       in   1   write address accepted (1-cycle pulse)
//  wr_idle         in   1   write controller idle with all data sent
//  rd_done_p       in   1   read burst checked (1-cycle pulse)
//  rd_err_p        in   1   read data mismatch (1-cycle pulse)
//  init_start      out  1   held high during S_INIT
//  write_en        out  1   request one write burst
//  read_en         out  1   request one read burst
//  rw_addr         out  CTRL_ADDR_WIDTH  burst address
//  axi_id          out  4   burst id
//  axi_len         out  4   burst length-1
//  axi_ap          out  1   auto-precharge
//  test_busy       out  1   high outside S_IDLE/S_DONE
//  test_pass       out  1   valid in S_DONE: err_cnt==0 and no timeout
//  err_cnt         out  16  saturating read-error count
//  burst_cnt       out  16  completed bursts in the current phase
//  timeout         out  1   watchdog fired (sticky until restart)
//  seq_state       out  3   FSM state, for debug
// BEHAVIOUR
//  - Reset: all outputs 0, state S_IDLE (0), LFSR = LFSR_SEED, axi_len = 0.
//  - States: S_IDLE=0, S_INIT=1, S_WR=2, S_WR_WAIT=3, S_RD=4, S_RD_WAIT=5, S_DONE=6.
//  - S_IDLE: a test_start rising edge clears err_cnt/burst_cnt/timeout, loads the
//    LFSR seed and goes to S_INIT.
//  - S_INIT: init_start=1. When init_done=1 go to S_WR the next cycle.
//  - S_WR: drive fields from the current LFSR, then set write_en=1 and go to S_WR_WAIT.
//    Fields are registered one cycle before the enable and held stable until the done pulse.
//  - S_WR_WAIT: on wr_done_p, drop write_en and wait for wr_idle.
//    Then: if write_to_read=1, go to S_RD with the same fields (LFSR not advanced).
//    Else burst_cnt++, advance the LFSR and axi_id++;
//    go to S_RD with the LFSR reloaded to the seed when burst_cnt reaches BURST_NUM.
//  - S_RD / S_RD_WAIT: the same as S_WR / S_WR_WAIT, using read_en and rd_done_p.
//    On completion burst_cnt++, advance the LFSR and axi_id++. After BURST_NUM reads go to S_DONE.
//    In write_to_read=1 mode, return to S_WR until BURST_NUM pairs are done.
//  - Address: rw_addr = {zeros, LFSR[MEM_SPACE_AW-8:0], 7'b0}, so a burst never crosses
//    a 128-unit block and never reaches 2**MEM_SPACE_AW.
//  - LFSR: 16-bit Fibonacci, taps 16,14,13,11; one step per completed burst. When
//    MEM_SPACE_AW-7 > 16, upper address bits are 0.
//  - err_cnt: +1 per rd_err_p in any state except S_IDLE; saturates at 16'hFFFF.
//    An rd_err_p coincident with rd_done_p is counted.
//  - S_DONE: test_pass registered; outputs held until test_start falls, then S_IDLE.
//  - test_start=0 in any busy state: enables drop the same cycle. The FSM waits
//    for wr_idle before S_IDLE, so no AXI transaction is orphaned.
//  - A done pulse outside its WAIT state is ignored.
// CONFIGURATION
//  SEQ_TIMEOUT_EN defined:
//   - A 16-bit watchdog counts in S_INIT and the WAIT states and clears on each state change.
//   - When it reaches TIMEOUT_CYC: timeout=1, enables drop, next state is S_DONE, test_pass=0.
//  SEQ_TIMEOUT_EN undefined: no counter; timeout tied to 0; the WAIT states wait forever.
// TESTING
//  1 BURST_NUM=4, write_to_read=1, ideal controller models -> order W,R,W,R,W,R,W,R;
//    burst_cnt=4; test_pass=1; each R uses the same rw_addr as the preceding W.
//  2 BURST_NUM=4, write_to_read=0 -> 4 W then 4 R; the read address sequence equals
//    the write sequence; axi_id continues incrementing 0..7.
//  3 Inject rd_err_p on 3 cycles, one coincident with rd_done_p -> err_cnt=3, test_pass=0.
//  4 Drop test_start in S_WR_WAIT with wr_idle held low 10 cycles -> write_en=0 at once;
//    S_IDLE only after wr_idle=1.
//  5 rand_len_en=0, rand_ap_en=0 -> axi_len=15, axi_ap=0, rw_addr[6:0]=0, and
//    rw_addr < 2**18 on all bursts.
//  6 SEQ_TIMEOUT_EN, TIMEOUT_CYC=100, rd_done_p never asserted -> timeout=1 100 cycles
//    after read_en rises; S_DONE; test_pass=0.

Source files
------------

// File: rtl/ddr_test_seq_ctrl.sv
// rtl/ddr_test_seq_ctrl.sv - DDR traffic test sequencer: init fill, write/read burst scheduling, error tally
// Optional watchdog enabled by defining SEQ_TIMEOUT_EN.
module ddr_test_seq_ctrl #(
   parameter int          CTRL_ADDR_WIDTH = 28,
   parameter int          MEM_SPACE_AW    = 18,
   parameter int          BURST_NUM       = 256,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1,
   parameter int          TIMEOUT_CYC     = 4096
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       test_start,
   input  logic                       write_to_read,
   input  logic                       rand_len_en,
   input  logic                       rand_ap_en,
   input  logic                       init_done,
   input  logic                       wr_done_p,
   input  logic                       wr_idle,
   input  logic                       rd_done_p,
   input  logic                       rd_err_p,
   output logic                       init_start,
   output logic                       write_en,
   output logic                       read_en,
   output logic [CTRL_ADDR_WIDTH-1:0] rw_addr,
   output logic [3:0]                 axi_id,
   output logic [3:0]                 axi_len,
   output logic                       axi_ap,
   output logic                       test_busy,
   output logic                       test_pass,
   output logic [15:0]                err_cnt,
   output logic [15:0]                burst_cnt,
   output logic                       timeout,
   output logic [2:0]                 seq_state
);

   localparam int          LW         = (MEM_SPACE_AW - 7 > 16) ? 16 : MEM_SPACE_AW - 7;
   localparam logic [15:0] BURST_LAST = 16'(BURST_NUM - 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_INIT    = 3'd1,
      S_WR      = 3'd2,
      S_WR_WAIT = 3'd3,
      S_RD      = 3'd4,
      S_RD_WAIT = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   typedef struct packed {
      logic [CTRL_ADDR_WIDTH-1:0] addr;
      logic [3:0]                 len;
      logic                       ap;
   } fields_t;

   state_t      r_state;
   fields_t     r_fields;
   logic [15:0] r_lfsr;
   logic [3:0]  r_id;
   logic [15:0] r_burst_cnt;
   logic [15:0] r_err_cnt;
   logic        r_start_d;
   logic        r_acked;
   logic        r_pass;
   logic        r_init_start;
   logic        r_write_en;
   logic        r_read_en;
   logic        w_busy;
   logic [15:0] w_lfsr_nxt;

   // Block-aligned address: low 7 bits zero so a 16-beat burst never crosses a 128-unit block
   function automatic fields_t f_fields(input logic [15:0] l, input logic len_rand,
                                        input logic ap_rand);
      fields_t f;
      f.addr = CTRL_ADDR_WIDTH'({l[LW-1:0], 7'b0});
      f.len  = len_rand ? l[3:0] : 4'd15;
      f.ap   = ap_rand & l[4];
      return f;
   endfunction

   assign w_lfsr_nxt = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_busy     = (r_state != S_IDLE) && (r_state != S_DONE);

`ifdef SEQ_TIMEOUT_EN
   localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYC - 1);
   logic        r_timeout;
   logic [15:0] r_wdog;
   logic        w_wdog_run;
   // Counting states are always entered from a non-counting state, so clearing outside them
   // is equivalent to clearing on every state change.
   assign w_wdog_run = (r_state == S_INIT) || (r_state == S_WR_WAIT) || (r_state == S_RD_WAIT);
   assign timeout    = r_timeout;
`else
   assign timeout    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_fields     <= '0;
         r_lfsr       <= LFSR_SEED;
         r_id         <= '0;
         r_burst_cnt  <= '0;
         r_err_cnt    <= '0;
         r_start_d    <= 1'b0;
         r_acked      <= 1'b0;
         r_pass       <= 1'b0;
         r_init_start <= 1'b0;
         r_write_en   <= 1'b0;
         r_read_en    <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
         r_timeout    <= 1'b0;
         r_wdog       <= '0;
`endif
      end else begin
         r_start_d <= test_start;
         if ((r_state != S_IDLE) && rd_err_p && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
`ifdef SEQ_TIMEOUT_EN
         r_wdog <= w_wdog_run ? r_wdog + 16'd1 : 16'd0;
`endif
         // Abort holds the FSM in place until the write side drains
         if (w_busy && !test_start) begin
            r_init_start <= 1'b0;
            r_write_en   <= 1'b0;
            r_read_en    <= 1'b0;
            if (wr_idle)
               r_state <= S_IDLE;
         end
`ifdef SEQ_TIMEOUT_EN
         else if (w_wdog_run && (r_wdog == WDOG_LAST)) begin
            r_timeout    <= 1'b1;
            r_init_start <= 1'b0;
            r_write_en   <= 1'b0;
            r_read_en    <= 1'b0;
            r_pass       <= 1'b0;
            r_state      <= S_DONE;
         end
`endif
         else begin
            case (r_state)
               S_IDLE: begin
                  if (test_start && !r_start_d) begin
                     r_err_cnt    <= '0;
                     r_burst_cnt  <= '0;
                     r_id         <= '0;
                     r_pass       <= 1'b0;
                     r_lfsr       <= LFSR_SEED;
                     r_init_start <= 1'b1;
`ifdef SEQ_TIMEOUT_EN
                     r_timeout    <= 1'b0;
`endif
                     r_state      <= S_INIT;
                  end
               end
               S_INIT: begin
                  if (init_done) begin
                     r_init_start <= 1'b0;
                     r_fields     <= f_fields(r_lfsr, rand_len_en, rand_ap_en);
                     r_state      <= S_WR;
                  end
               end
               S_WR: begin
                  r_write_en <= 1'b1;
                  r_acked    <= 1'b0;
                  r_state    <= S_WR_WAIT;
               end
               S_WR_WAIT: begin
                  if (!r_acked) begin
                     if (wr_done_p) begin
                        r_write_en <= 1'b0;
                        r_acked    <= 1'b1;
                     end
                  end else if (wr_idle) begin
                     if (write_to_read) begin
                        r_state <= S_RD;
                     end else if (r_burst_cnt == BURST_LAST) begin
                        r_burst_cnt <= '0;
                        r_id        <= r_id + 4'd1;
                        r_lfsr      <= LFSR_SEED;
                        r_fields    <= f_fields(LFSR_SEED, rand_len_en, rand_ap_en);
                        r_state     <= S_RD;
                     end else begin
                        r_burst_cnt <= r_burst_cnt + 16'd1;
                        r_id        <= r_id + 4'd1;
                        r_lfsr      <= w_lfsr_nxt;
                        r_fields    <= f_fields(w_lfsr_nxt, rand_len_en, rand_ap_en);
                        r_state     <= S_WR;
                     end
                  end
               end
               S_RD: begin
                  r_read_en <= 1'b1;
                  r_state   <= S_RD_WAIT;
               end
               S_RD_WAIT: begin
                  if (rd_done_p) begin
                     r_read_en   <= 1'b0;
                     r_burst_cnt <= r_burst_cnt + 16'd1;
                     r_id        <= r_id + 4'd1;
                     r_lfsr      <= w_lfsr_nxt;
                     r_fields    <= f_fields(w_lfsr_nxt, rand_len_en, rand_ap_en);
                     if (r_burst_cnt == BURST_LAST) begin
                        r_pass  <= (r_err_cnt == 16'd0) && !rd_err_p;
                        r_state <= S_DONE;
                     end else begin
                        r_state <= write_to_read ? S_WR : S_RD;
                     end
                  end
               end
               S_DONE: begin
                  r_pass <= r_pass && !rd_err_p;
                  if (!test_start)
                     r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign init_start = r_init_start & test_start;
   assign write_en   = r_write_en & test_start;
   assign read_en    = r_read_en & test_start;
   assign rw_addr    = r_fields.addr;
   assign axi_len    = r_fields.len;
   assign axi_ap     = r_fields.ap;
   assign axi_id     = r_id;
   assign test_busy  = w_busy;
   assign test_pass  = r_pass;
   assign err_cnt    = r_err_cnt;
   assign burst_cnt  = r_burst_cnt;
   assign seq_state  = r_state;

endmodule

// File: tb/tb_ddr_test_seq_ctrl.sv
// tb/tb_ddr_test_seq_ctrl.sv - directed bench for ddr_test_seq_ctrl with hand-computed LFSR fields
module tb_ddr_test_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        test_start, write_to_read, rand_len_en, rand_ap_en;
   logic        init_done, wr_done_p, wr_idle, rd_done_p, rd_err_p;
   logic        init_start, write_en, read_en;
   logic [27:0] rw_addr;
   logic [3:0]  axi_id, axi_len;
   logic        axi_ap, test_busy, test_pass, timeout;
   logic [15:0] err_cnt, burst_cnt;
   logic [2:0]  seq_state;

   int n_pass  = 0;
   int n_total = 0;

   // Seed ACE1 stepped by taps 16,14,13,11: ACE1, 59C3, B387, 670F
   logic [27:0] e_addr [4] = '{28'h27080, 28'h0E180, 28'h1C380, 28'h38780};
   logic [3:0]  e_len  [4] = '{4'h1, 4'h3, 4'h7, 4'hF};

   ddr_test_seq_ctrl #(
      .CTRL_ADDR_WIDTH(28), .MEM_SPACE_AW(18), .BURST_NUM(4),
      .LFSR_SEED(16'hACE1), .TIMEOUT_CYC(100)
   ) dut (
      .clk(clk), .rst(rst), .test_start(test_start), .write_to_read(write_to_read),
      .rand_len_en(rand_len_en), .rand_ap_en(rand_ap_en), .init_done(init_done),
      .wr_done_p(wr_done_p), .wr_idle(wr_idle), .rd_done_p(rd_done_p), .rd_err_p(rd_err_p),
      .init_start(init_start), .write_en(write_en), .read_en(read_en), .rw_addr(rw_addr),
      .axi_id(axi_id), .axi_len(axi_len), .axi_ap(axi_ap), .test_busy(test_busy),
      .test_pass(test_pass), .err_cnt(err_cnt), .burst_cnt(burst_cnt), .timeout(timeout),
      .seq_state(seq_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_time_limit observed=running expected=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic wait_state(input string tag, input logic [2:0] s);
      int t;
      t = 0;
      while (seq_state !== s && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk(tag, 32'(seq_state), 32'(s));
   endtask

   task automatic start_test(input string tag, input bit err_in_init);
      test_start = 1'b1;
      @(negedge clk);
      chk({tag, "_init_state"}, 32'(seq_state), 32'd1);
      chk({tag, "_init_start"}, 32'(init_start), 32'd1);
      if (err_in_init) begin
         rd_err_p = 1'b1;
         @(negedge clk);
         rd_err_p = 1'b0;
         chk({tag, "_init_err"}, 32'(err_cnt), 32'd1);
      end
      init_done = 1'b1;
      @(negedge clk);
      init_done = 1'b0;
      chk({tag, "_wr_state"}, 32'(seq_state), 32'd2);
   endtask

   task automatic burst(input string tag, input bit is_rd, input int k, input logic [3:0] e_id,
                        input bit rnd, input bit err);
      int t;
      t = 0;
      while (!write_en && !read_en && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk({tag, "_en"},    32'(is_rd ? read_en : write_en), 32'd1);
      chk({tag, "_other"}, 32'(is_rd ? write_en : read_en), 32'd0);
      chk({tag, "_addr"},  32'(rw_addr), 32'(e_addr[k]));
      chk({tag, "_blk"},   32'(rw_addr[6:0]), 32'd0);
      chk({tag, "_range"}, 32'(rw_addr < 28'h40000), 32'd1);
      chk({tag, "_id"},    32'(axi_id), 32'(e_id));
      chk({tag, "_len"},   32'(axi_len), rnd ? 32'(e_len[k]) : 32'd15);
      chk({tag, "_ap"},    32'(axi_ap), 32'd0);
      if (is_rd) begin
         rd_done_p = 1'b1;
         rd_err_p  = err;
      end else begin
         wr_done_p = 1'b1;
         wr_idle   = 1'b0;
      end
      @(negedge clk);
      rd_done_p = 1'b0;
      rd_err_p  = 1'b0;
      wr_done_p = 1'b0;
      chk({tag, "_drop"}, 32'(is_rd ? read_en : write_en), 32'd0);
      if (!is_rd) begin
         repeat (2) @(negedge clk);
         wr_idle = 1'b1;
      end
      @(negedge clk);
   endtask

   initial begin
      int t;
      rst = 1'b1;
      test_start = 1'b0; write_to_read = 1'b0; rand_len_en = 1'b0; rand_ap_en = 1'b0;
      init_done = 1'b0; wr_done_p = 1'b0; wr_idle = 1'b1; rd_done_p = 1'b0; rd_err_p = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_state",  32'(seq_state), 32'd0);
      chk("rst_wr_en",  32'(write_en), 32'd0);
      chk("rst_rd_en",  32'(read_en), 32'd0);
      chk("rst_init",   32'(init_start), 32'd0);
      chk("rst_addr",   32'(rw_addr), 32'd0);
      chk("rst_len",    32'(axi_len), 32'd0);
      chk("rst_id",     32'(axi_id), 32'd0);
      chk("rst_err",    32'(err_cnt), 32'd0);
      chk("rst_bcnt",   32'(burst_cnt), 32'd0);
      chk("rst_busy",   32'(test_busy), 32'd0);
      chk("rst_pass",   32'(test_pass), 32'd0);
      chk("rst_tmo",    32'(timeout), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      // Test 1: interleaved W,R pairs reading back the same address
      write_to_read = 1'b1; rand_len_en = 1'b1; rand_ap_en = 1'b1;
      start_test("t1", 1'b0);
      for (int i = 0; i < 4; i++) begin
         burst("t1w", 1'b0, i, 4'(i), 1'b1, 1'b0);
         burst("t1r", 1'b1, i, 4'(i), 1'b1, 1'b0);
      end
      wait_state("t1_done", 3'd6);
      chk("t1_bcnt", 32'(burst_cnt), 32'd4);
      chk("t1_pass", 32'(test_pass), 32'd1);
      chk("t1_busy", 32'(test_busy), 32'd0);
      test_start = 1'b0;
      @(negedge clk);
      chk("t1_idle", 32'(seq_state), 32'd0);

      // Test 2: all writes then all reads, same address order, id keeps counting
      write_to_read = 1'b0;
      start_test("t2", 1'b0);
      for (int i = 0; i < 4; i++) burst("t2w", 1'b0, i, 4'(i), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) burst("t2r", 1'b1, i, 4'(4 + i), 1'b1, 1'b0);
      wait_state("t2_done", 3'd6);
      chk("t2_bcnt", 32'(burst_cnt), 32'd4);
      chk("t2_pass", 32'(test_pass), 32'd1);
      test_start = 1'b0;
      @(negedge clk);

      // Tests 3 and 5: three errors (one with rd_done_p), fixed len/ap
      write_to_read = 1'b1; rand_len_en = 1'b0; rand_ap_en = 1'b0;
      start_test("t3", 1'b1);
      burst("t3w", 1'b0, 0, 4'd0, 1'b0, 1'b0);
      burst("t3r", 1'b1, 0, 4'd0, 1'b0, 1'b1);
      chk("t3_err2", 32'(err_cnt), 32'd2);
      rd_err_p = 1'b1;
      @(negedge clk);
      rd_err_p = 1'b0;
      for (int i = 1; i < 4; i++) begin
         burst("t3w", 1'b0, i, 4'(i), 1'b0, 1'b0);
         burst("t3r", 1'b1, i, 4'(i), 1'b0, 1'b0);
      end
      wait_state("t3_done", 3'd6);
      chk("t3_err", 32'(err_cnt), 32'd3);
      chk("t3_pass", 32'(test_pass), 32'd0);
      test_start = 1'b0;
      @(negedge clk);

      // Test 4: abort during S_WR_WAIT while the write side is still busy
      write_to_read = 1'b1; rand_len_en = 1'b1; rand_ap_en = 1'b1;
      start_test("t4", 1'b0);
      t = 0;
      while (!write_en && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t4_wr_en", 32'(write_en), 32'd1);
      test_start = 1'b0;
      wr_idle    = 1'b0;
      #1;
      chk("t4_drop_now", 32'(write_en), 32'd0);
      repeat (10) @(negedge clk);
      chk("t4_hold_state", 32'(seq_state), 32'd3);
      chk("t4_hold_en", 32'(write_en), 32'd0);
      wr_idle = 1'b1;
      @(negedge clk);
      chk("t4_idle", 32'(seq_state), 32'd0);
      chk("t4_busy", 32'(test_busy), 32'd0);

`ifdef SEQ_TIMEOUT_EN
      // Test 6: read never completes, watchdog fires 100 cycles after read_en
      start_test("t6", 1'b0);
      burst("t6w", 1'b0, 0, 4'd0, 1'b1, 1'b0);
      t = 0;
      while (!read_en && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("t6_rd_en", 32'(read_en), 32'd1);
      repeat (99) @(negedge clk);
      chk("t6_tmo_early", 32'(timeout), 32'd0);
      @(negedge clk);
      chk("t6_tmo", 32'(timeout), 32'd1);
      chk("t6_state", 32'(seq_state), 32'd6);
      chk("t6_pass", 32'(test_pass), 32'd0);
      chk("t6_rd_drop", 32'(read_en), 32'd0);
      test_start = 1'b0;
      @(negedge clk);
      chk("t6_idle", 32'(seq_state), 32'd0);
`else
      chk("no_timeout", 32'(timeout), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
